// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier request scheduler.
package mult_sched_pkg;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      WAIT_FULL = 2'd1,
      DRAIN     = 2'd2
   } state_t;

   localparam int OP_W          = 16;
   localparam int MULT_LAT      = 4;
   localparam int DEPTH_DEFAULT = 64;
   localparam int ID_W_MAX      = 3;

   // id is sized for the largest supported requester count (8)
   typedef struct packed {
      logic                dummy;
      logic [ID_W_MAX-1:0] id;
   } tag_t;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic                    en,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] ptr_nxt
);

   localparam int PW = $clog2(NREQ);

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % NREQ;
      return PW'(s);
   endfunction

   // Scan from the farthest candidate back to ptr so the nearest valid one wins.
   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      if (en) begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) begin
               grant                   = '0;
               grant[wrap_add(ptr, k)] = 1'b1;
               ptr_nxt                 = wrap_add(ptr, k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/mult_sched.sv
// Schedules requester operations onto the pipelined multiplier in blocks of DEPTH
// and returns each block's results tagged with the originating requester.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   FILL      | granting requesters (or padding after a flush) until DEPTH issued
//   WAIT_FULL | block issued; EN_blockRead held until the first VALID_memVal
//   DRAIN     | popping one tag per VALID_memVal until DEPTH results consumed
module mult_sched
   import mult_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int N     = 32,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                    CLK,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*OP_W-1:0]    req_op0,
   input  logic [NREQ*OP_W-1:0]    req_op1,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    flush,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [N-1:0]            rsp_data,
   output logic                    EN_mult,
   output logic [OP_W-1:0]         mult_input0,
   output logic [OP_W-1:0]         mult_input1,
   input  logic                    RDY_mult,
   output logic                    EN_blockRead,
   input  logic                    VALID_memVal,
   input  logic [N-1:0]            memVal_data
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int AW    = $clog2(DEPTH);

   state_t           state;
   logic             live;
   logic             pend;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] popped;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  ptr_nxt;
   logic [NREQ-1:0]  grant;

   logic             arb_en;
   logic             xfer;
   logic             pad;
   logic             pop;
   logic             last_pop;
   logic             room;
   logic [ID_W-1:0]  grant_id;
   logic [OP_W-1:0]  sel_op0;
   logic [OP_W-1:0]  sel_op1;
   tag_t             push_tag;
   tag_t             pop_tag;
   tag_t             fifo [DEPTH];

   // live keeps req_ready low while rst_n is asserted, even with requesters valid
   assign room     = live && (state == FILL) && RDY_mult && (issued < CNT_W'(DEPTH));
   assign arb_en   = room && !pend;
   assign pad      = room && pend;
   assign xfer     = |grant;
   assign pop      = VALID_memVal && (state != FILL);
   assign last_pop = pop && (popped == CNT_W'(DEPTH - 1));

   assign req_ready = grant;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req_valid),
      .en      (arb_en),
      .ptr     (ptr),
      .grant   (grant),
      .ptr_nxt (ptr_nxt)
   );

   always_comb begin
      grant_id = '0;
      sel_op0  = '0;
      sel_op1  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            grant_id = ID_W'(i);
            sel_op0  = req_op0[OP_W*i +: OP_W];
            sel_op1  = req_op1[OP_W*i +: OP_W];
         end
      end
   end

   always_comb begin
      push_tag       = '0;
      push_tag.dummy = !xfer;
      push_tag.id    = ID_W_MAX'(grant_id);
   end

   // Results come back in issue order, so the write index is simply the issue count
   always_ff @(posedge CLK) begin
      if (xfer || pad)
         fifo[issued[AW-1:0]] <= push_tag;
   end

   assign pop_tag = fifo[popped[AW-1:0]];

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FILL;
         live         <= 1'b0;
         pend         <= 1'b0;
         issued       <= '0;
         popped       <= '0;
         ptr          <= '0;
         EN_mult      <= 1'b0;
         mult_input0  <= '0;
         mult_input1  <= '0;
         EN_blockRead <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_data     <= '0;
      end else begin
         live      <= 1'b1;
         EN_mult   <= xfer || pad;
         rsp_valid <= 1'b0;

         if (xfer) begin
            mult_input0 <= sel_op0;
            mult_input1 <= sel_op1;
            ptr         <= ptr_nxt;
         end else if (pad) begin
            mult_input0 <= '0;
            mult_input1 <= '0;
         end

         case (state)
            FILL: begin
               if (flush && (issued != '0))
                  pend <= 1'b1;
               if (xfer || pad) begin
                  issued <= issued + CNT_W'(1);
                  if (issued == CNT_W'(DEPTH - 1)) begin
                     state        <= WAIT_FULL;
                     EN_blockRead <= 1'b1;
                  end
               end
            end

            WAIT_FULL, DRAIN: begin
               if (pop) begin
                  EN_blockRead <= 1'b0;
                  state        <= DRAIN;
                  popped       <= popped + CNT_W'(1);
                  if (!pop_tag.dummy) begin
                     rsp_valid <= 1'b1;
                     rsp_id    <= ID_W'(pop_tag.id);
                     rsp_data  <= memVal_data;
                  end
                  if (last_pop) begin
                     state  <= FILL;
                     issued <= '0;
                     popped <= '0;
                     pend   <= 1'b0;
                  end
               end
            end

            default: state <= FILL;
         endcase
      end
   end

endmodule
